// File: rtl/intr_ctrl.sv
// Parametrised N-source interrupt controller: latched status, mask, priority vector,
// pulse/level CPU interrupt line. Define INTR_COUNT_EN to add per-source event counters.
module intr_ctrl #(
  parameter int unsigned NUM_INTR    = 4,
  parameter int unsigned OUT_MODE    = 0,
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned HOLDOFF_LEN = 2,
  localparam int unsigned VW = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [NUM_INTR-1:0] intr_signal_i,
  input  logic [NUM_INTR-1:0] intr_force_i,
  input  logic [NUM_INTR-1:0] intr_clear_i,
  input  logic [NUM_INTR-1:0] intr_mask_i,
  output logic [NUM_INTR-1:0] intr_status_o,
  output logic [NUM_INTR-1:0] intr_pending_o,
  output logic                intr_valid_o,
  output logic [VW-1:0]       intr_vector_o,
`ifdef INTR_COUNT_EN
  input  logic [VW-1:0]       intr_count_sel_i,
  output logic [7:0]          intr_count_o,
`endif
  output logic                bus_intr_o
);

  localparam int unsigned MAX_LEN = (PULSE_LEN > HOLDOFF_LEN) ? PULSE_LEN : HOLDOFF_LEN;
  localparam int unsigned CW      = $clog2(MAX_LEN + 1);

  logic [NUM_INTR-1:0] set_c;
  logic [NUM_INTR-1:0] status_d, status_q;
  logic [NUM_INTR-1:0] pending_d, pending_q;
  logic [VW-1:0]       vector_d, vector_q;
  logic                valid_q;

  // Set wins over clear so a strobe coinciding with a clear is never lost
  always_comb begin
    set_c     = intr_signal_i | intr_force_i;
    status_d  = (status_q & ~intr_clear_i) | set_c;
    pending_d = status_d & intr_mask_i;
  end

  // Fixed priority, bit 0 highest
  always_comb begin
    vector_d = '0;
    for (int i = int'(NUM_INTR) - 1; i >= 0; i--) begin
      if (pending_d[i]) vector_d = VW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      status_q  <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      vector_q  <= '0;
    end else begin
      status_q  <= status_d;
      pending_q <= pending_d;
      valid_q   <= |pending_d;
      vector_q  <= vector_d;
    end
  end

  assign intr_status_o  = status_q;
  assign intr_pending_o = pending_q;
  assign intr_valid_o   = valid_q;
  assign intr_vector_o  = vector_q;

  generate
    if (OUT_MODE == 1) begin : g_level
      assign bus_intr_o = valid_q;
    end else begin : g_pulse
      typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_e;

      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          retrig_q, retrig_d;
      logic          bus_q, bus_d;
      logic          new_evt_c;

      // Only a 0->1 transition of an enabled bit is a new event
      assign new_evt_c = |(set_c & intr_mask_i & ~status_q);

      always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          retrig_q <= 1'b0;
          bus_q    <= 1'b0;
        end else begin
          state_q  <= state_d;
          cnt_q    <= cnt_d;
          retrig_q <= retrig_d;
          bus_q    <= bus_d;
        end
      end

      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retrig_d = retrig_q;
        case (state_q)
          IDLE: begin
            if (new_evt_c) begin
              state_d = ASSERT;
              cnt_d   = CW'(PULSE_LEN - 1);
            end
          end
          ASSERT: begin
            if (new_evt_c) retrig_d = 1'b1;
            if (cnt_q == '0) begin
              state_d = HOLDOFF;
              cnt_d   = CW'(HOLDOFF_LEN - 1);
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          HOLDOFF: begin
            if (new_evt_c) retrig_d = 1'b1;
            if (cnt_q == '0) begin
              // An event arriving on the final holdoff cycle still retriggers
              retrig_d = 1'b0;
              if ((retrig_q || new_evt_c) && (|pending_d)) begin
                state_d = ASSERT;
                cnt_d   = CW'(PULSE_LEN - 1);
              end else begin
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            retrig_d = 1'b0;
          end
        endcase
        bus_d = (state_d == ASSERT);
      end

      assign bus_intr_o = bus_q;
    end
  endgenerate

`ifdef INTR_COUNT_EN
  logic [NUM_INTR-1:0][7:0] evt_cnt_d, evt_cnt_q;
  logic [7:0]               count_d, count_q;

  // Saturating per-source counters; clear beats increment
  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(NUM_INTR); i++) begin
      evt_cnt_d[i] = evt_cnt_q[i];
      if (intr_clear_i[i]) begin
        evt_cnt_d[i] = '0;
      end else if (set_c[i] && intr_mask_i[i] && (evt_cnt_q[i] != 8'hFF)) begin
        evt_cnt_d[i] = evt_cnt_q[i] + 8'd1;
      end
      if (VW'(i) == intr_count_sel_i) count_d = evt_cnt_d[i];
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      evt_cnt_q <= '0;
      count_q   <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
      count_q   <= count_d;
    end
  end

  assign intr_count_o = count_q;
`endif

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: three instances (pulse 1/2, pulse 3/4, level)
// share stimulus and are compared each cycle against a reference model.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig, frc, clr, msk;

  logic [3:0] st_a, pd_a, st_b, pd_b, st_c, pd_c;
  logic       v_a, v_b, v_c, bus_a, bus_b, bus_c;
  logic [1:0] vec_a, vec_b, vec_c;
`ifdef INTR_COUNT_EN
  logic [1:0] sel = 2'd2;
  logic [7:0] cnt_a, cnt_b, cnt_c;
`endif

  typedef struct packed {
    logic [3:0]      st;
    logic [3:0]      pend;
    logic            valid;
    logic [1:0]      vec;
    logic            bus;
    int              phase;   // 0 idle, 1 asserting, 2 holdoff
    int              left;    // cycles remaining in current phase
    logic            retrig;
    logic [3:0][7:0] cnt;
  } mdl_t;

  typedef struct packed {
    mdl_t a;
    mdl_t b;
    mdl_t c;
  } exp_t;

  exp_t sb_q[$];
  mdl_t m_a, m_b, m_c;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.NUM_INTR(4), .OUT_MODE(0), .PULSE_LEN(1), .HOLDOFF_LEN(2)) u_a (
    .clk(clk), .reset_i(rst), .intr_signal_i(sig), .intr_force_i(frc),
    .intr_clear_i(clr), .intr_mask_i(msk), .intr_status_o(st_a),
    .intr_pending_o(pd_a), .intr_valid_o(v_a), .intr_vector_o(vec_a),
`ifdef INTR_COUNT_EN
    .intr_count_sel_i(sel), .intr_count_o(cnt_a),
`endif
    .bus_intr_o(bus_a));

  intr_ctrl #(.NUM_INTR(4), .OUT_MODE(0), .PULSE_LEN(3), .HOLDOFF_LEN(4)) u_b (
    .clk(clk), .reset_i(rst), .intr_signal_i(sig), .intr_force_i(frc),
    .intr_clear_i(clr), .intr_mask_i(msk), .intr_status_o(st_b),
    .intr_pending_o(pd_b), .intr_valid_o(v_b), .intr_vector_o(vec_b),
`ifdef INTR_COUNT_EN
    .intr_count_sel_i(sel), .intr_count_o(cnt_b),
`endif
    .bus_intr_o(bus_b));

  intr_ctrl #(.NUM_INTR(4), .OUT_MODE(1), .PULSE_LEN(1), .HOLDOFF_LEN(2)) u_c (
    .clk(clk), .reset_i(rst), .intr_signal_i(sig), .intr_force_i(frc),
    .intr_clear_i(clr), .intr_mask_i(msk), .intr_status_o(st_c),
    .intr_pending_o(pd_c), .intr_valid_o(v_c), .intr_vector_o(vec_c),
`ifdef INTR_COUNT_EN
    .intr_count_sel_i(sel), .intr_count_o(cnt_c),
`endif
    .bus_intr_o(bus_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference behaviour for a single instance
  function automatic mdl_t mstep(input mdl_t m, input logic [3:0] s, input logic [3:0] f,
                                 input logic [3:0] c, input logic [3:0] mk,
                                 input int omode, input int plen, input int hlen);
    mdl_t       n;
    logic [3:0] set;
    logic [3:0] pd_n;
    bit         evt;
    n    = m;
    set  = s | f;
    n.st = (m.st & ~c) | set;
    pd_n = n.st & mk;
    evt  = |(set & mk & ~m.st);
    n.pend  = pd_n;
    n.valid = |pd_n;
    n.vec   = 2'd0;
    for (int i = 3; i >= 0; i--) if (pd_n[i]) n.vec = 2'(i);
    if (omode == 1) begin
      n.bus = |pd_n;
    end else begin
      case (m.phase)
        0: if (evt) begin n.phase = 1; n.left = plen; end
        1: begin
          if (evt) n.retrig = 1'b1;
          if (m.left == 1) begin n.phase = 2; n.left = hlen; end
          else n.left = m.left - 1;
        end
        default: begin
          if (m.left == 1) begin
            if ((m.retrig || evt) && (|pd_n)) begin n.phase = 1; n.left = plen; end
            else n.phase = 0;
            n.retrig = 1'b0;
          end else begin
            n.left = m.left - 1;
            if (evt) n.retrig = 1'b1;
          end
        end
      endcase
      n.bus = (n.phase == 1);
    end
    for (int i = 0; i < 4; i++) begin
      if (c[i]) n.cnt[i] = 8'd0;
      else if (set[i] && mk[i] && (m.cnt[i] != 8'hFF)) n.cnt[i] = m.cnt[i] + 8'd1;
    end
    return n;
  endfunction

  task automatic cmp_one(input string p, input mdl_t e, input logic [3:0] st, input logic [3:0] pd,
                         input logic v, input logic [1:0] vec, input logic bus);
    check({p, ".status"},  32'(st),  32'(e.st));
    check({p, ".pending"}, 32'(pd),  32'(e.pend));
    check({p, ".valid"},   32'(v),   32'(e.valid));
    check({p, ".vector"},  32'(vec), 32'(e.vec));
    check({p, ".bus"},     32'(bus), 32'(e.bus));
  endtask

  // Drive one cycle of stimulus, push expectation, compare after the edge
  task automatic cyc(input logic [3:0] s, input logic [3:0] f, input logic [3:0] c);
    exp_t e;
    sig = s; frc = f; clr = c;
    m_a = mstep(m_a, s, f, c, msk, 0, 1, 2);
    m_b = mstep(m_b, s, f, c, msk, 0, 3, 4);
    m_c = mstep(m_c, s, f, c, msk, 1, 1, 2);
    e.a = m_a; e.b = m_b; e.c = m_c;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb.empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      cmp_one("a", e.a, st_a, pd_a, v_a, vec_a, bus_a);
      cmp_one("b", e.b, st_b, pd_b, v_b, vec_b, bus_b);
      cmp_one("c", e.c, st_c, pd_c, v_c, vec_c, bus_c);
`ifdef INTR_COUNT_EN
      check("a.count", 32'(cnt_a), 32'(e.a.cnt[2]));
      check("c.count", 32'(cnt_c), 32'(e.c.cnt[2]));
`endif
    end
    sig = '0; frc = '0; clr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'b0, 4'b0, 4'b0);
  endtask

  initial begin
    rst = 1'b1; sig = '0; frc = '0; clr = '0; msk = '0;
    m_a = '0; m_b = '0; m_c = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.status", 32'(st_a), 32'd0);
    check("rst.valid",  32'(v_a),  32'd0);
    check("rst.vector", 32'(vec_a), 32'd0);
    check("rst.bus_a",  32'(bus_a), 32'd0);
    check("rst.bus_c",  32'(bus_c), 32'd0);
    rst = 1'b0;

    // Single enabled source: 1-cycle pulse then 2 holdoff cycles
    msk = 4'b0100;
    cyc(4'b0100, 4'b0, 4'b0);
    check("t1.status", 32'(st_a), 32'h4);
    check("t1.vector", 32'(vec_a), 32'd2);
    check("t1.valid",  32'(v_a), 32'd1);
    check("t1.bus_hi", 32'(bus_a), 32'd1);
    cyc(4'b0, 4'b0, 4'b0);
    check("t1.bus_lo", 32'(bus_a), 32'd0);
    idle(2);
    cyc(4'b0, 4'b0, 4'b0100);
    idle(8);

    // Masked source latches; unmasking later is not a new event
    msk = 4'b0000;
    cyc(4'b0010, 4'b0, 4'b0);
    check("t2.status",  32'(st_a), 32'h2);
    check("t2.pending", 32'(pd_a), 32'h0);
    check("t2.bus",     32'(bus_a), 32'd0);
    msk = 4'b0010;
    cyc(4'b0, 4'b0, 4'b0);
    check("t2.pend_um", 32'(pd_a), 32'h2);
    check("t2.nopulse", 32'(bus_a), 32'd0);
    idle(2);

    // Set and clear together keep the bit
    cyc(4'b1000, 4'b0, 4'b0);
    cyc(4'b1000, 4'b0, 4'b1000);
    check("t3.setclr", 32'(st_a), 32'ha);
    cyc(4'b0, 4'b0, 4'b1111);
    idle(8);

    // Second source (via force) during ASSERT retriggers 7 cycles after first rise
    msk = 4'b1111;
    cyc(4'b0001, 4'b0, 4'b0);
    check("t4.rise", 32'(bus_b), 32'd1);
    cyc(4'b0, 4'b0100, 4'b0);
    for (int k = 2; k < 16; k++) begin
      cyc(4'b0, 4'b0, 4'b0);
      if (k == 6) check("t4.hold_lo", 32'(bus_b), 32'd0);
      if (k == 7) check("t4.retrig",  32'(bus_b), 32'd1);
    end
    cyc(4'b0, 4'b0, 4'b1111);
    idle(4);

    // Same, but all pending cleared during HOLDOFF: no second pulse
    cyc(4'b0001, 4'b0, 4'b0);
    cyc(4'b0, 4'b0100, 4'b0);
    for (int k = 2; k < 16; k++) begin
      if (k == 4) cyc(4'b0, 4'b0, 4'b0101);
      else        cyc(4'b0, 4'b0, 4'b0);
      if (k == 7) check("t5.cancel", 32'(bus_b), 32'd0);
    end

    // Level mode
    cyc(4'b1001, 4'b0, 4'b0);
    check("t6.bus",  32'(bus_c), 32'd1);
    check("t6.vec0", 32'(vec_c), 32'd0);
    cyc(4'b0, 4'b0, 4'b0001);
    check("t6.vec3", 32'(vec_c), 32'd3);
    cyc(4'b0, 4'b0, 4'b1000);
    check("t6.bus_lo", 32'(bus_c), 32'd0);
    idle(8);

`ifdef INTR_COUNT_EN
    // Counter saturation and clear
    msk = 4'b0100;
    cyc(4'b0, 4'b0, 4'b1111);
    repeat (300) cyc(4'b0100, 4'b0, 4'b0);
    check("t7.sat", 32'(cnt_a), 32'hFF);
    cyc(4'b0, 4'b0, 4'b0100);
    check("t7.clr", 32'(cnt_a), 32'h0);
    idle(8);
`endif

    // Asynchronous reset in the middle of a pulse
    msk = 4'b1111;
    cyc(4'b0, 4'b0, 4'b1111);
    idle(8);
    cyc(4'b0001, 4'b0, 4'b0);
    check("t8.pre_a", 32'(bus_a), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t8.bus_a",  32'(bus_a), 32'd0);
    check("t8.bus_b",  32'(bus_b), 32'd0);
    check("t8.bus_c",  32'(bus_c), 32'd0);
    check("t8.status", 32'(st_a), 32'd0);
    check("t8.pend",   32'(pd_a), 32'd0);
    check("t8.valid",  32'(v_b), 32'd0);
    m_a = '0; m_b = '0; m_c = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    cyc(4'b0010, 4'b0, 4'b0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
